// File: rtl/tetris_stat_pkg.sv
// rtl/tetris_stat_pkg.sv - shared types and constants for the stat text writer
package tetris_stat_pkg;

    typedef logic [5:0][3:0] bcd6_t;

    typedef enum logic [1:0] {
        FIELD_SCORE,
        FIELD_LINES,
        FIELD_LEVEL
    } field_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam logic [7:0] CHAR_SPACE  = 8'h20;
    localparam logic [7:0] CHAR_ZERO   = 8'h30;
    localparam logic [7:0] CHAR_BAD    = 8'h3F;
    localparam int         STAT_DIGITS = 6;

endpackage

// File: rtl/tetris_stat_text_writer_if.sv
// rtl/tetris_stat_text_writer_if.sv - character buffer write port
interface tetris_stat_text_writer_if #(
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0] char_addr;
    logic [7:0]        char_code;
    logic              char_valid;
    logic              char_ready;

    modport master (
        output char_addr,
        output char_code,
        output char_valid,
        input  char_ready
    );

    modport slave (
        input  char_addr,
        input  char_code,
        input  char_valid,
        output char_ready
    );
endinterface

// File: rtl/bcd_char_enc.sv
// rtl/bcd_char_enc.sv - one BCD digit to its on-screen character code
module bcd_char_enc
    import tetris_stat_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [7:0] code
);

    // illegal digits show '?', blanked zeros show a space, the rest are ASCII digits
    always_comb begin
        code = CHAR_ZERO + {4'd0, digit};
        if (digit > 4'd9) begin
            code = CHAR_BAD;
        end else if (blank && (digit == 4'd0)) begin
            code = CHAR_SPACE;
        end
    end

endmodule

// File: rtl/tetris_stat_text_writer.sv
// rtl/tetris_stat_text_writer.sv - writes score/lines/level as text into the char buffer
module tetris_stat_text_writer
    import tetris_stat_pkg::*;
#(
    parameter int ADDR_W     = 11,
    parameter int SCORE_BASE = 96,
    parameter int LINES_BASE = 224,
    parameter int LEVEL_BASE = 352
)(
    input  logic                       clk_i,
    input  logic                       srst_n_i,
    input  bcd6_t                      score_i,
    input  bcd6_t                      lines_i,
    input  bcd6_t                      level_i,
    input  logic                       stat_update_i,
    tetris_stat_text_writer_if.master  char_bus,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam logic [2:0] TOP_IDX = 3'(STAT_DIGITS - 1);

    state_t            state_q, state_d;
    field_t            field_q, nf;
    logic [2:0]        idx_q, ni;
    logic              lz_q, lz_d, nb;
    logic              pending_q, pending_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        code_q, enc_code;
    bcd6_t             snap_score_q, snap_lines_q, snap_level_q;
    bcd6_t             src_bcd;
    logic [3:0]        digit;
    logic              enc_blank;
    logic              snap_load, advance, xfer, last_char;
    logic [ADDR_W-1:0] base;

    assign xfer      = valid_q & char_bus.char_ready;
    assign last_char = (field_q == FIELD_LEVEL) && (idx_q == 3'd0);

    // next state, pending request and the position of the next character to present
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        valid_d   = valid_q;
        snap_load = 1'b0;
        advance   = 1'b0;
        nf        = FIELD_SCORE;
        ni        = TOP_IDX;
        nb        = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (pending_q || stat_update_i) begin
                    state_d   = ST_SEND;
                    pending_d = 1'b0;
                    snap_load = 1'b1;
                    advance   = 1'b1;
                    valid_d   = 1'b1;
                end
            end
            ST_SEND: begin
                if (stat_update_i) pending_d = 1'b1;
                if (xfer) begin
                    if (last_char) begin
                        valid_d = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        advance = 1'b1;
                        if (idx_q == 3'd0) begin
                            nf = (field_q == FIELD_SCORE) ? FIELD_LINES : FIELD_LEVEL;
                        end else begin
                            nf = field_q;
                            ni = idx_q - 3'd1;
                            nb = lz_q;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (stat_update_i) pending_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // digit source, blanking decision and address of the next character
    always_comb begin
        src_bcd = score_i;
        base    = ADDR_W'(SCORE_BASE);
        if (state_q != ST_IDLE) begin
            case (nf)
                FIELD_LINES: src_bcd = snap_lines_q;
                FIELD_LEVEL: src_bcd = snap_level_q;
                default:     src_bcd = snap_score_q;
            endcase
        end
        case (nf)
            FIELD_LINES: base = ADDR_W'(LINES_BASE);
            FIELD_LEVEL: base = ADDR_W'(LEVEL_BASE);
            default:     base = ADDR_W'(SCORE_BASE);
        endcase
        digit     = src_bcd[ni];
        enc_blank = nb && (ni != 3'd0);
        lz_d      = nb && (digit == 4'd0);
        addr_d    = base + ADDR_W'(TOP_IDX - ni);
    end

    bcd_char_enc u_enc (
        .digit (digit),
        .blank (enc_blank),
        .code  (enc_code)
    );

    // control state register
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
        end
    end

    // snapshot and presented character; held while the buffer stalls
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            field_q      <= FIELD_SCORE;
            idx_q        <= 3'd0;
            lz_q         <= 1'b0;
            addr_q       <= '0;
            code_q       <= 8'h00;
            snap_score_q <= '0;
            snap_lines_q <= '0;
            snap_level_q <= '0;
        end else begin
            if (snap_load) begin
                snap_score_q <= score_i;
                snap_lines_q <= lines_i;
                snap_level_q <= level_i;
            end
            if (advance) begin
                field_q <= nf;
                idx_q   <= ni;
                lz_q    <= lz_d;
                addr_q  <= addr_d;
                code_q  <= enc_code;
            end
        end
    end

    assign char_bus.char_addr  = addr_q;
    assign char_bus.char_code  = code_q;
    assign char_bus.char_valid = valid_q;
    assign busy_o              = (state_q != ST_IDLE);
    assign done_o              = (state_q == ST_DONE);

endmodule

// File: tb/tb_tetris_stat_text_writer.sv
// tb/tb_tetris_stat_text_writer.sv - self-checking bench for tetris_stat_text_writer
module tb_tetris_stat_text_writer;
    import tetris_stat_pkg::*;

    logic  clk = 1'b0;
    logic  srst_n;
    bcd6_t score, lines, level;
    logic  upd;
    logic  busy, done;

    always #5 clk = ~clk;

    tetris_stat_text_writer_if #(.ADDR_W(11)) cbus();

    tetris_stat_text_writer #(
        .ADDR_W(11), .SCORE_BASE(96), .LINES_BASE(224), .LEVEL_BASE(352)
    ) u_dut (
        .clk_i         (clk),
        .srst_n_i      (srst_n),
        .score_i       (score),
        .lines_i       (lines),
        .level_i       (level),
        .stat_update_i (upd),
        .char_bus      (cbus.master),
        .busy_o        (busy),
        .done_o        (done)
    );

    int vectors = 0;
    int miscompares = 0;
    int rdy_mode = 0;
    int wr_cnt = 0;
    int done_pulses = 0;
    logic [10:0] exp_addr_q[$];
    logic [7:0]  exp_code_q[$];
    logic [10:0] log_addr[0:17];
    logic [7:0]  log_code[0:17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: text of one field from the display rules
    task automatic push_field(input bcd6_t v, input logic [10:0] base);
        bit lead;
        logic [3:0] d;
        logic [7:0] c;
        lead = 1'b1;
        for (int i = 5; i >= 0; i--) begin
            d = v[i];
            if (d > 4'd9) begin
                c = 8'h3F;
                lead = 1'b0;
            end else if (d == 4'd0 && lead && i > 0) begin
                c = 8'h20;
            end else begin
                c = 8'h30 + {4'd0, d};
                lead = 1'b0;
            end
            exp_addr_q.push_back(base + 11'(5 - i));
            exp_code_q.push_back(c);
        end
    endtask

    task automatic push_refresh(input bcd6_t s, input bcd6_t l, input bcd6_t v);
        push_field(s, 11'd96);
        push_field(l, 11'd224);
        push_field(v, 11'd352);
    endtask

    function automatic bcd6_t rand_bcd();
        bcd6_t v;
        for (int i = 0; i < 6; i++) begin
            case ($urandom % 8)
                0, 1, 2: v[i] = 4'd0;
                3:       v[i] = 4'($urandom_range(10, 15));
                default: v[i] = 4'($urandom_range(0, 9));
            endcase
        end
        return v;
    endfunction

    task automatic check_field(input string name, input int f, input logic [47:0] exp);
        for (int i = 0; i < 6; i++)
            check(name, 32'(log_code[f*6+i]), 32'(exp[47-8*i -: 8]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int start;
        int n;
        start = done_pulses;
        n = 0;
        while (done_pulses == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_pulses == start) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: no done_o within %0d cycles", budget);
        end
    endtask

    task automatic pulse_update();
        upd = 1'b1;
        tick();
        upd = 1'b0;
    endtask

    // buffer-side ready: always, random backpressure, or stalled
    initial begin
        cbus.char_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       cbus.char_ready = 1'b1;
                1:       cbus.char_ready = (($urandom % 3) != 0);
                default: cbus.char_ready = 1'b0;
            endcase
        end
    end

    // compare every accepted write against the reference queue, plus hold/done rules
    initial begin
        bit prev_stall;
        bit prev_done;
        logic [10:0] prev_addr;
        logic [7:0]  prev_code;
        prev_stall = 1'b0;
        prev_done = 1'b0;
        prev_addr = '0;
        prev_code = '0;
        forever begin
            @(negedge clk);
            if (!srst_n) begin
                exp_addr_q.delete();
                exp_code_q.delete();
                wr_cnt = 0;
                prev_stall = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 32'(cbus.char_valid), 32'd1);
                    check("hold_addr", 32'(cbus.char_addr), 32'(prev_addr));
                    check("hold_code", 32'(cbus.char_code), 32'(prev_code));
                end
                prev_stall = cbus.char_valid && !cbus.char_ready;
                prev_addr = cbus.char_addr;
                prev_code = cbus.char_code;
                if (cbus.char_valid && cbus.char_ready) begin
                    if (exp_addr_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_write: addr %0d code %0h with nothing expected",
                                 cbus.char_addr, cbus.char_code);
                    end else begin
                        check("wr_addr", 32'(cbus.char_addr), 32'(exp_addr_q.pop_front()));
                        check("wr_code", 32'(cbus.char_code), 32'(exp_code_q.pop_front()));
                    end
                    if (wr_cnt < 18) begin
                        log_addr[wr_cnt] = cbus.char_addr;
                        log_code[wr_cnt] = cbus.char_code;
                    end
                    wr_cnt++;
                end
                if (done) begin
                    check("done_after_18", 32'(wr_cnt), 32'd18);
                    check("done_single", 32'(prev_done), 32'd0);
                    check("busy_in_done", 32'(busy), 32'd1);
                    done_pulses++;
                    wr_cnt = 0;
                end
                prev_done = done;
            end
        end
    end

    initial begin
        int d0;
        int n;
        srst_n = 1'b0;
        upd = 1'b0;
        score = '0;
        lines = '0;
        level = '0;
        rdy_mode = 0;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(cbus.char_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(cbus.char_addr), 32'd0);
        check("rst_code", 32'(cbus.char_code), 32'd0);

        // automatic refresh after reset release, all zeros
        tick();
        srst_n = 1'b1;
        push_refresh(score, lines, level);
        wait_done(100);
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("done_count_1", 32'(done_pulses), 32'd1);
        check_field("zero_score", 0, 48'h202020202030);
        check_field("zero_lines", 1, 48'h202020202030);
        check_field("zero_level", 2, 48'h202020202030);
        check("addr_first", 32'(log_addr[0]), 32'd96);
        check("addr_score_last", 32'(log_addr[5]), 32'd101);
        check("addr_lines_first", 32'(log_addr[6]), 32'd224);
        check("addr_level_first", 32'(log_addr[12]), 32'd352);
        check("addr_level_last", 32'(log_addr[17]), 32'd357);

        // update pulse with known values, one-cycle latency
        tick();
        score = 24'h001500;
        lines = 24'h000012;
        level = 24'h000002;
        push_refresh(score, lines, level);
        upd = 1'b1;
        @(negedge clk);
        check("valid_before_start", 32'(cbus.char_valid), 32'd0);
        tick();
        upd = 1'b0;
        @(negedge clk);
        check("latency_valid", 32'(cbus.char_valid), 32'd1);
        check("latency_addr", 32'(cbus.char_addr), 32'd96);
        wait_done(100);
        check_field("score_1500", 0, 48'h202031353030);
        check_field("lines_12", 1, 48'h202020203132);
        check_field("level_2", 2, 48'h202020202032);

        // random values under random backpressure
        rdy_mode = 1;
        for (int it = 0; it < 8; it++) begin
            tick();
            score = rand_bcd();
            lines = rand_bcd();
            level = rand_bcd();
            push_refresh(score, lines, level);
            pulse_update();
            wait_done(400);
            @(negedge clk);
            check("rand_idle_busy", 32'(busy), 32'd0);
            check("rand_drained", 32'(exp_addr_q.size()), 32'd0);
        end

        // three requests during a refresh collapse into one extra refresh
        tick();
        d0 = done_pulses;
        score = 24'h000777;
        lines = rand_bcd();
        level = rand_bcd();
        push_refresh(score, lines, level);
        pulse_update();
        repeat (2) tick();
        pulse_update();
        score = 24'h000100;
        tick();
        pulse_update();
        tick();
        pulse_update();
        push_refresh(score, lines, level);
        wait_done(400);
        wait_done(400);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("collapse_done_count", 32'(done_pulses - d0), 32'd2);
        check("collapse_idle", 32'(busy), 32'd0);
        check("collapse_drained", 32'(exp_addr_q.size()), 32'd0);
        check_field("score_100", 0, 48'h202020313030);

        // reset after the 7th transfer of a refresh
        rdy_mode = 0;
        tick();
        score = rand_bcd();
        lines = rand_bcd();
        level = rand_bcd();
        push_refresh(score, lines, level);
        pulse_update();
        n = 0;
        while (wr_cnt < 7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reached_7th", 32'(wr_cnt >= 7), 32'd1);
        tick();
        srst_n = 1'b0;
        tick();
        srst_n = 1'b1;
        @(negedge clk);
        check("valid_after_reset", 32'(cbus.char_valid), 32'd0);
        push_refresh(score, lines, level);
        wait_done(100);
        check("restart_addr", 32'(log_addr[0]), 32'd96);

        // illegal digit counts as nonzero
        tick();
        score = 24'h000A00;
        lines = '0;
        level = '0;
        push_refresh(score, lines, level);
        pulse_update();
        wait_done(100);
        check_field("score_bad", 0, 48'h2020203F3030);
        @(negedge clk);
        check("final_drained", 32'(exp_addr_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
